pri_icache_ctrl_master: RTL
===========================

// Module: pri_icache_ctrl_master
//
// PURPOSE
// Peripheral-side initiator for the private icache control channel (PRI_ICACHE_CTRL_UNIT_BUS master end).
// Decodes XBAR_PERIPH_BUS slave accesses from the SoC peripheral interconnect.
// Drives bypass/flush/selective-flush request-acknowledge handshakes towards the icache, which is the slave end.
// Exposes handshake status, and optionally statistics counters, as readable registers.
//
// PARAMETERS
// ID_WIDTH    9     width of id_i / r_id_o (NB_CORES+1 for 8 cores)
// BYPASS_RST  1'b1  reset value of bypass_req_o (1 = cache bypassed out of reset)
//
// PORTS
// clk_i             in   1         clock; single domain
// rst_ni            in   1         async reset, active low
// req_i             in   1         periph request
// add_i             in   32        byte address; add_i[5:2] selects register
// wen_i             in   1         1 = read, 0 = write
// wdata_i           in   32        write data
// be_i              in   4         byte enables (ignored; full-word registers)
// id_i              in   ID_WIDTH  requester id
// gnt_o             out  1         grant (combinational)
// r_valid_o         out  1         response valid
// r_opc_o           out  1         0 = OK, 1 = error (unmapped offset)
// r_id_o            out  ID_WIDTH  response id
// r_rdata_o         out  32        read data
// bypass_req_o      out  1         level: 1 = request bypass
// bypass_ack_i      in   1         level: icache bypass state
// flush_req_o       out  1         full flush request
// flush_ack_i       in   1         full flush done
// sel_flush_req_o   out  1         selective flush request
// sel_flush_addr_o  out  32        selective flush address
// sel_flush_ack_i   in   1         selective flush done
//
// BEHAVIOUR
// Register map (add_i[5:2]):
// - 0 ENABLE: W bit0 = 1 enables (bypass_req_o = 0), = 0 bypasses. R {31'b0, ~bypass_req_o}.
// - 1 FLUSH: W any value starts a full flush. R 0.
// - 2 SEL_FLUSH: W latches address and starts a selective flush. R last address.
// - 3 STATUS (R only): {29'b0, sel_busy, flush_busy, bypass_ack_i}.
// - 4-8: statistics block (see CONFIGURATION); any other offset is unmapped.
// Grant:
// - gnt_o = req_i && !stall.
// - stall is asserted for:
//   - a FLUSH or SEL_FLUSH write while either flush FSM is non-idle;
//   - an ENABLE write while bypass_ack_i != bypass_req_o.
// - Reads never stall.
// Response:
// - Registered; r_valid_o rises exactly 1 cycle after the gnt_o cycle and lasts 1 cycle.
// - r_id_o = id_i captured at grant.
// - Back-to-back granted requests give back-to-back responses.
// - Writes return r_rdata_o = 0.
// - Unmapped offset: r_opc_o = 1, r_rdata_o = 0, no side effect. Writes to STATUS take the same path.
// Flush FSM (full and selective are identical, independent state regs):
// - IDLE: on a granted write go to REQ; req_o = 1 from the next cycle.
// - REQ: hold req_o = 1 until ack_i is sampled 1. Then go to IDLE; req_o = 0 in the following cycle.
// - ack_i while in IDLE is ignored.
// - The two FSMs are mutually exclusive through the stall rule; at most one is ever in REQ.
// - ack in the same cycle as a new FLUSH write: the write stalls that cycle and is granted the next.
// - sel_flush_addr_o is stable throughout REQ.
// Bypass:
// - bypass_req_o updates the cycle after the granted ENABLE write and is a level signal.
// Reset values:
// - gnt_o = 0 (req_i = 0), r_valid_o = 0, r_opc_o = 0, r_id_o = 0, r_rdata_o = 0.
// - flush_req_o = 0, sel_flush_req_o = 0, sel_flush_addr_o = 0, bypass_req_o = BYPASS_RST, FSMs in IDLE.
// Reset mid-operation:
// - Async clear of all state; outstanding requests drop immediately.
// - A late ack after reset is ignored in IDLE.
//
// CONFIGURATION
// Macro: PRI_ICACHE_CTRL_STAT_EN.
// Defined:
// - Adds inputs hit_count_i, trans_count_i, miss_count_i, cong_count_i [31:0].
// - Adds outputs clear_regs_o and enable_regs_o.
// - Offsets 4-7 read the four counters.
// - Offset 8 CTRL:
//   - W bit0 = 1 pulses clear_regs_o high for exactly 1 cycle, the cycle after the grant.
//   - W bit1 sets enable_regs_o, which is a level, reset 0.
//   - R {30'b0, enable_regs_o, 1'b0}.
// Undefined: ports absent; offsets 4-8 are unmapped (r_opc_o = 1).
//
// TESTING
// - Reset, then R STATUS with bypass_ack_i = 1 -> r_valid 1 cycle after gnt, rdata 0x1, r_opc 0, r_id echoes id_i.
// - W ENABLE = 1; ack follows 3 cycles later -> bypass_req_o 0 the next cycle.
//   A second ENABLE write stalls until bypass_ack_i = 0.
// - W FLUSH; flush_ack_i after 5 cycles -> flush_req_o high for 6 cycles.
//   A SEL_FLUSH write issued meanwhile is not granted until flush_req_o = 0.
// - W SEL_FLUSH = 0x1C00_8040 -> sel_flush_addr_o = 0x1C00_8040 and sel_flush_req_o held until ack.
//   Then R SEL_FLUSH returns 0x1C00_8040.
// - Read offset 0xF (and 4 without the macro) -> r_opc_o = 1, rdata 0, no state change.
// - Assert rst_ni low during FLUSH REQ -> flush_req_o 0 immediately; a later flush_ack_i pulse causes no activity.
//   With PRI_ICACHE_CTRL_STAT_EN defined: W CTRL = 0x3 -> one-cycle clear_regs_o and enable_regs_o = 1.

Source files
------------

// File: rtl/pri_icache_ctrl_master.sv
// pri_icache_ctrl_master
//
// Peripheral-side initiator of the private icache control channel. Decodes
// single-word accesses from the peripheral interconnect and turns them into
// bypass / full-flush / selective-flush handshakes towards the icache.
//
// Configuration macro: PRI_ICACHE_CTRL_STAT_EN
//   undefined : offsets 4-8 are unmapped (error response)
//   defined   : offsets 4-7 read the statistics counters, offset 8 is CTRL
//               (clear_regs_o one-cycle pulse, enable_regs_o level)
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i .. id_i          peripheral slave request (add_i[5:2] = register)
//   gnt_o                  combinational grant
//   r_valid_o .. r_rdata_o registered response, one cycle after grant
//   bypass_req_o/ack_i     level bypass handshake
//   flush_req_o/ack_i      full flush request/acknowledge
//   sel_flush_*            selective flush request, address, acknowledge
//
// Register map (add_i[5:2])
//   0 ENABLE    W bit0=1 enable cache, R {31'b0, ~bypass_req_o}
//   1 FLUSH     W starts full flush, R 0
//   2 SEL_FLUSH W latches address and starts selective flush, R last address
//   3 STATUS    R {29'b0, sel_busy, flush_busy, bypass_ack_i}, W is an error

module pri_icache_ctrl_master #(
  parameter int unsigned ID_WIDTH   = 9,
  parameter logic        BYPASS_RST = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
`ifdef PRI_ICACHE_CTRL_STAT_EN
  input  logic [31:0]         hit_count_i,
  input  logic [31:0]         trans_count_i,
  input  logic [31:0]         miss_count_i,
  input  logic [31:0]         cong_count_i,
  output logic                clear_regs_o,
  output logic                enable_regs_o,
`endif
  output logic                bypass_req_o,
  input  logic                bypass_ack_i,
  output logic                flush_req_o,
  input  logic                flush_ack_i,
  output logic                sel_flush_req_o,
  output logic [31:0]         sel_flush_addr_o,
  input  logic                sel_flush_ack_i
);

  localparam logic [3:0] OFF_ENABLE = 4'd0;
  localparam logic [3:0] OFF_FLUSH  = 4'd1;
  localparam logic [3:0] OFF_SEL    = 4'd2;
  localparam logic [3:0] OFF_STATUS = 4'd3;

  typedef enum logic [0:0] {FL_IDLE = 1'b0, FL_REQ = 1'b1} fl_state_e;

  fl_state_e           flush_state_q, flush_state_d;
  fl_state_e           sel_state_q, sel_state_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         sel_addr_q, sel_addr_d;
  logic                r_valid_q, r_valid_d;
  logic                r_opc_q, r_opc_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [31:0]         r_rdata_q, r_rdata_d;
`ifdef PRI_ICACHE_CTRL_STAT_EN
  logic                clear_q, clear_d;
  logic                enable_q, enable_d;
`endif

  logic [3:0] off_s;
  logic       is_wr_s;
  logic       flush_busy_s;
  logic       sel_busy_s;
  logic       stall_s;
  logic       gnt_s;
  logic       flush_start_s;
  logic       sel_start_s;
  logic       unused_s;

  assign off_s        = add_i[5:2];
  assign is_wr_s      = ~wen_i;
  assign flush_busy_s = (flush_state_q != FL_IDLE);
  assign sel_busy_s   = (sel_state_q != FL_IDLE);
  assign unused_s     = ^{add_i[31:6], add_i[1:0], be_i};

  // Stall decision: only writes that would disturb an ongoing handshake wait.
  always_comb begin
    stall_s = 1'b0;
    if (req_i && is_wr_s) begin
      case (off_s)
        OFF_ENABLE:        stall_s = (bypass_ack_i != bypass_q);
        OFF_FLUSH, OFF_SEL: stall_s = flush_busy_s || sel_busy_s;
        default:           stall_s = 1'b0;
      endcase
    end else begin
      stall_s = 1'b0;
    end
  end

  assign gnt_s = req_i && !stall_s;
  assign gnt_o = gnt_s;

  // Register decode: side effects and response payload of a granted access.
  always_comb begin
    bypass_d      = bypass_q;
    sel_addr_d    = sel_addr_q;
    flush_start_s = 1'b0;
    sel_start_s   = 1'b0;
    r_valid_d     = gnt_s;
    r_id_d        = r_id_q;
    r_opc_d       = 1'b0;
    r_rdata_d     = 32'h0000_0000;
`ifdef PRI_ICACHE_CTRL_STAT_EN
    clear_d       = 1'b0;
    enable_d      = enable_q;
`endif
    if (gnt_s) begin
      r_id_d = id_i;
      case (off_s)
        OFF_ENABLE: begin
          if (is_wr_s) bypass_d = ~wdata_i[0];
          else         r_rdata_d = {31'h0000_0000, ~bypass_q};
        end
        OFF_FLUSH: begin
          if (is_wr_s) flush_start_s = 1'b1;
          else         r_rdata_d = 32'h0000_0000;
        end
        OFF_SEL: begin
          if (is_wr_s) begin
            sel_addr_d  = wdata_i;
            sel_start_s = 1'b1;
          end else begin
            r_rdata_d = sel_addr_q;
          end
        end
        OFF_STATUS: begin
          if (is_wr_s) r_opc_d = 1'b1;
          else         r_rdata_d = {29'h0000_0000, sel_busy_s, flush_busy_s, bypass_ack_i};
        end
`ifdef PRI_ICACHE_CTRL_STAT_EN
        4'd4: begin
          if (is_wr_s) r_opc_d = 1'b1;
          else         r_rdata_d = hit_count_i;
        end
        4'd5: begin
          if (is_wr_s) r_opc_d = 1'b1;
          else         r_rdata_d = trans_count_i;
        end
        4'd6: begin
          if (is_wr_s) r_opc_d = 1'b1;
          else         r_rdata_d = miss_count_i;
        end
        4'd7: begin
          if (is_wr_s) r_opc_d = 1'b1;
          else         r_rdata_d = cong_count_i;
        end
        4'd8: begin
          if (is_wr_s) begin
            clear_d  = wdata_i[0];
            enable_d = wdata_i[1];
          end else begin
            r_rdata_d = {30'h0000_0000, enable_q, 1'b0};
          end
        end
`endif
        default: r_opc_d = 1'b1;
      endcase
    end else begin
      r_opc_d   = 1'b0;
      r_rdata_d = 32'h0000_0000;
    end
  end

  // Full flush FSM next state; ack outside REQ has no effect.
  always_comb begin
    flush_state_d = flush_state_q;
    case (flush_state_q)
      FL_IDLE: begin
        if (flush_start_s) flush_state_d = FL_REQ;
        else               flush_state_d = FL_IDLE;
      end
      FL_REQ: begin
        if (flush_ack_i) flush_state_d = FL_IDLE;
        else             flush_state_d = FL_REQ;
      end
      default: flush_state_d = FL_IDLE;
    endcase
  end

  // Selective flush FSM next state; same protocol as the full flush.
  always_comb begin
    sel_state_d = sel_state_q;
    case (sel_state_q)
      FL_IDLE: begin
        if (sel_start_s) sel_state_d = FL_REQ;
        else             sel_state_d = FL_IDLE;
      end
      FL_REQ: begin
        if (sel_flush_ack_i) sel_state_d = FL_IDLE;
        else                 sel_state_d = FL_REQ;
      end
      default: sel_state_d = FL_IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_state_q <= FL_IDLE;
      sel_state_q   <= FL_IDLE;
      bypass_q      <= BYPASS_RST;
      sel_addr_q    <= 32'h0000_0000;
      r_valid_q     <= 1'b0;
      r_opc_q       <= 1'b0;
      r_id_q        <= '0;
      r_rdata_q     <= 32'h0000_0000;
`ifdef PRI_ICACHE_CTRL_STAT_EN
      clear_q       <= 1'b0;
      enable_q      <= 1'b0;
`endif
    end else begin
      flush_state_q <= flush_state_d;
      sel_state_q   <= sel_state_d;
      bypass_q      <= bypass_d;
      sel_addr_q    <= sel_addr_d;
      r_valid_q     <= r_valid_d;
      r_opc_q       <= r_opc_d;
      r_id_q        <= r_id_d;
      r_rdata_q     <= r_rdata_d;
`ifdef PRI_ICACHE_CTRL_STAT_EN
      clear_q       <= clear_d;
      enable_q      <= enable_d;
`endif
    end
  end

  assign r_valid_o        = r_valid_q;
  assign r_opc_o          = r_opc_q;
  assign r_id_o           = r_id_q;
  assign r_rdata_o        = r_rdata_q;
  assign bypass_req_o     = bypass_q;
  assign flush_req_o      = (flush_state_q == FL_REQ);
  assign sel_flush_req_o  = (sel_state_q == FL_REQ);
  assign sel_flush_addr_o = sel_addr_q;
`ifdef PRI_ICACHE_CTRL_STAT_EN
  assign clear_regs_o     = clear_q;
  assign enable_regs_o    = enable_q;
`endif

endmodule
